// File: rtl/training_sample_feeder_pkg.sv
// Shared definitions for the training sample feeder.
//   feeder_state_e : FSM state encoding (idle, loading, serving)
//   T_POS / T_NEG  : target encodings for +1 / -1
//   DEFAULT_X_W/T_W: default feature and target widths
package training_sample_feeder_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StServe = 2'd2
  } feeder_state_e;

  localparam logic [1:0] T_POS = 2'b01;
  localparam logic [1:0] T_NEG = 2'b11;

  localparam int unsigned DEFAULT_X_W = 7;
  localparam int unsigned DEFAULT_T_W = 2;

endpackage

// File: rtl/training_sample_feeder_sample_ram.sv
// Single-clock sample RAM, DEPTH x W, one write port and one synchronous read port.
// The read data register doubles as the feeder's output register: it clears on rst
// and otherwise only changes when re is high, so it holds the last served sample.
// Ports:
//   clk, rst        : clock, synchronous active-high reset (read register only)
//   we, waddr, wdata: write port
//   re, raddr       : read request and address
//   rdata           : registered read data
module training_sample_feeder_sample_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6,
  parameter int unsigned W     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/training_sample_feeder.sv
// Training sample feeder: a host loads (x1, x2, target) samples, then the learner
// pulls them back one per readEn, wrapping around forever and flagging each epoch end.
// Optional build macro FEEDER_EPOCH_LIMIT_EN stops serving after MAX_EPOCHS epochs.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   wrEn, wrX1, wrX2, wrT    : host write of one sample (IDLE/LOAD only)
//   loadDone                 : commit the loaded set and start serving
//   clear                    : drop all samples and return to IDLE
//   readEn                   : learner request for the next sample
//   x1Data, x2Data, tData    : served sample (registered, latency 1)
//   sampleValid              : outputs hold a served sample
//   epochEnd                 : pulse with the last stored sample
//   full, count, serving     : store status
module training_sample_feeder
  import training_sample_feeder_pkg::*;
#(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned AW         = 6,
  parameter int unsigned X_W        = DEFAULT_X_W,
  parameter int unsigned T_W        = DEFAULT_T_W,
  parameter int unsigned MAX_EPOCHS = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wrEn,
  input  logic [X_W-1:0] wrX1,
  input  logic [X_W-1:0] wrX2,
  input  logic [T_W-1:0] wrT,
  input  logic           loadDone,
  input  logic           clear,
  input  logic           readEn,
  output logic [X_W-1:0] x1Data,
  output logic [X_W-1:0] x2Data,
  output logic [T_W-1:0] tData,
  output logic           sampleValid,
  output logic           epochEnd,
  output logic           full,
  output logic [AW:0]    count,
  output logic           serving
);

  localparam int unsigned SW = 2 * X_W + T_W;
  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  feeder_state_e state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          valid_q, valid_d;
  logic          epoch_end_q, epoch_end_d;
  logic          serving_q, serving_d;
  logic          wr_fire, rd_fire, rd_last, limit_hit, limit_d;
  logic [SW-1:0] rdata;

`ifdef FEEDER_EPOCH_LIMIT_EN
  localparam int unsigned EW = $clog2(MAX_EPOCHS + 1);
  logic [EW-1:0] epoch_cnt_q, epoch_cnt_d;
  assign limit_hit = (epoch_cnt_q >= EW'(MAX_EPOCHS));
  assign limit_d   = (epoch_cnt_d >= EW'(MAX_EPOCHS));
`else
  logic unused_max_epochs;
  assign unused_max_epochs = ^MAX_EPOCHS;
  assign limit_hit = 1'b0;
  assign limit_d   = 1'b0;
`endif

  assign full    = (count_q == FullCount);
  assign wr_fire = !clear && wrEn && !full && (state_q != StServe);
  assign rd_fire = !clear && readEn && (state_q == StServe) && !limit_hit;
  assign rd_last = ({1'b0, rd_ptr_q} == count_q - (AW+1)'(1));

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    valid_d     = valid_q;
    epoch_end_d = 1'b0;
`ifdef FEEDER_EPOCH_LIMIT_EN
    epoch_cnt_d = epoch_cnt_q;
`endif
    if (clear) begin
      state_d  = StIdle;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
`ifdef FEEDER_EPOCH_LIMIT_EN
      epoch_cnt_d = '0;
`endif
    end else begin
      if (wr_fire) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        count_d  = count_q + (AW+1)'(1);
        if (state_q == StIdle) state_d = StLoad;
      end
      // Uses the post-write count so a same-cycle write + loadDone commits that sample.
      if (state_q != StServe && loadDone && count_d != '0) begin
        state_d = StServe;
      end
      if (rd_fire) begin
        rd_ptr_d    = rd_last ? '0 : rd_ptr_q + AW'(1);
        valid_d     = 1'b1;
        epoch_end_d = rd_last;
`ifdef FEEDER_EPOCH_LIMIT_EN
        if (rd_last) epoch_cnt_d = epoch_cnt_q + EW'(1);
`endif
      end
    end
    serving_d = (state_d == StServe) && !limit_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      epoch_end_q <= 1'b0;
      serving_q   <= 1'b0;
`ifdef FEEDER_EPOCH_LIMIT_EN
      epoch_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      epoch_end_q <= epoch_end_d;
      serving_q   <= serving_d;
`ifdef FEEDER_EPOCH_LIMIT_EN
      epoch_cnt_q <= epoch_cnt_d;
`endif
    end
  end

  training_sample_feeder_sample_ram #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .W    (SW)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_fire),
    .waddr(wr_ptr_q),
    .wdata({wrX1, wrX2, wrT}),
    .re   (rd_fire),
    .raddr(rd_ptr_q),
    .rdata(rdata)
  );

  assign x1Data      = rdata[SW-1 -: X_W];
  assign x2Data      = rdata[T_W +: X_W];
  assign tData       = rdata[T_W-1:0];
  assign sampleValid = valid_q;
  assign epochEnd    = epoch_end_q;
  assign count       = count_q;
  assign serving     = serving_q;

endmodule

// File: tb/tb_training_sample_feeder.sv
module tb_training_sample_feeder;
  import training_sample_feeder_pkg::*;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned AW         = 2;
  localparam int unsigned X_W        = 7;
  localparam int unsigned T_W        = 2;
  localparam int unsigned MAX_EPOCHS = 2;

  logic           clk = 1'b0;
  logic           rst, wrEn, loadDone, clear, readEn;
  logic [X_W-1:0] wrX1, wrX2, x1Data, x2Data;
  logic [T_W-1:0] wrT, tData;
  logic           sampleValid, epochEnd, full, serving;
  logic [AW:0]    count;

  training_sample_feeder #(
    .DEPTH     (DEPTH),
    .AW        (AW),
    .X_W       (X_W),
    .T_W       (T_W),
    .MAX_EPOCHS(MAX_EPOCHS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wrEn       (wrEn),
    .wrX1       (wrX1),
    .wrX2       (wrX2),
    .wrT        (wrT),
    .loadDone   (loadDone),
    .clear      (clear),
    .readEn     (readEn),
    .x1Data     (x1Data),
    .x2Data     (x2Data),
    .tData      (tData),
    .sampleValid(sampleValid),
    .epochEnd   (epochEnd),
    .full       (full),
    .count      (count),
    .serving    (serving)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a list of stored samples, a replay index and an epoch tally.
  logic [X_W-1:0] m_x1 [DEPTH];
  logic [X_W-1:0] m_x2 [DEPTH];
  logic [T_W-1:0] m_t  [DEPTH];
  int             m_n, m_rd, m_epochs, m_phase;  // phase: 0 idle, 1 load, 2 serve
  logic [X_W-1:0] o_x1, o_x2;
  logic [T_W-1:0] o_t;
  logic           o_valid, o_eend;

  function automatic bit m_limited();
`ifdef FEEDER_EPOCH_LIMIT_EN
    return m_epochs >= MAX_EPOCHS;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_step();
    bit was_serve;
    if (rst) begin
      m_n = 0; m_rd = 0; m_epochs = 0; m_phase = 0;
      o_x1 = '0; o_x2 = '0; o_t = '0; o_valid = 0; o_eend = 0;
    end else if (clear) begin
      m_n = 0; m_rd = 0; m_epochs = 0; m_phase = 0; o_valid = 0; o_eend = 0;
    end else begin
      was_serve = (m_phase == 2);
      o_eend = 0;
      if (!was_serve && wrEn && m_n < DEPTH) begin
        m_x1[m_n] = wrX1; m_x2[m_n] = wrX2; m_t[m_n] = wrT;
        m_n++;
        if (m_phase == 0) m_phase = 1;
      end
      if (!was_serve && loadDone && m_n > 0) m_phase = 2;
      if (was_serve && readEn && !m_limited()) begin
        o_x1 = m_x1[m_rd]; o_x2 = m_x2[m_rd]; o_t = m_t[m_rd];
        o_valid = 1;
        if (m_rd == m_n - 1) begin
          m_rd = 0; o_eend = 1; m_epochs++;
        end else begin
          m_rd++;
        end
      end
    end
  endtask

  task automatic check_all();
    check_eq("x1Data", 32'(x1Data), 32'(o_x1));
    check_eq("x2Data", 32'(x2Data), 32'(o_x2));
    check_eq("tData", 32'(tData), 32'(o_t));
    check_eq("sampleValid", 32'(sampleValid), 32'(o_valid));
    check_eq("epochEnd", 32'(epochEnd), 32'(o_eend));
    check_eq("full", 32'(full), 32'(m_n == DEPTH));
    check_eq("count", 32'(count), 32'(m_n));
    check_eq("serving", 32'(serving), 32'(m_phase == 2 && !m_limited()));
  endtask

  task automatic cycle(input logic r, input logic w, input logic [X_W-1:0] a,
                       input logic [X_W-1:0] b, input logic [T_W-1:0] t,
                       input logic ld, input logic cl, input logic rd);
    @(negedge clk);
    rst = r; wrEn = w; wrX1 = a; wrX2 = b; wrT = t; loadDone = ld; clear = cl; readEn = rd;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle();
    cycle(0, 0, '0, '0, '0, 0, 0, 0);
  endtask

  task automatic wr(input logic [X_W-1:0] a, input logic [X_W-1:0] b,
                    input logic [T_W-1:0] t);
    cycle(0, 1, a, b, t, 0, 0, 0);
  endtask

  task automatic rd1();
    cycle(0, 0, '0, '0, '0, 0, 0, 1);
  endtask

  logic [X_W-1:0] exp_x1 [4];
  logic [X_W-1:0] exp_x2 [4];
  logic [T_W-1:0] exp_t  [4];
  int             eend_seen;
  logic [X_W-1:0] held_x1;

  initial begin
    exp_x1 = '{7'd5, 7'h79, 7'd0, 7'd5};
    exp_x2 = '{7'h7d, 7'd2, 7'd1, 7'h7d};
    exp_t  = '{T_POS, T_NEG, T_POS, T_POS};

    // Reset, then loadDone with nothing stored is ignored.
    cycle(1, 0, '0, '0, '0, 0, 0, 0);
    cycle(1, 0, '0, '0, '0, 0, 0, 0);
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_x1", 32'(x1Data), 0);
    cycle(0, 0, '0, '0, '0, 1, 0, 0);
    check_eq("empty_ld_serving", 32'(serving), 0);

    // Load three samples and replay with spaced pulses.
    wr(7'd5, 7'h7d, T_POS);
    wr(7'h79, 7'd2, T_NEG);
    wr(7'd0, 7'd1, T_POS);
    cycle(0, 0, '0, '0, '0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      rd1();
      check_eq("ls_x1", 32'(x1Data), 32'(exp_x1[i]));
      check_eq("ls_x2", 32'(x2Data), 32'(exp_x2[i]));
      check_eq("ls_t", 32'(tData), 32'(exp_t[i]));
      check_eq("ls_eend", 32'(epochEnd), 32'(i == 2));
      idle();
    end

    // Overflow: fifth write dropped, replay wraps after four.
    cycle(0, 0, '0, '0, '0, 0, 1, 0);
    for (int i = 0; i < 5; i++) wr(7'(i + 10), 7'(i + 20), T_POS);
    check_eq("ovf_full", 32'(full), 1);
    check_eq("ovf_count", 32'(count), 4);
    cycle(0, 0, '0, '0, '0, 1, 0, 0);
    for (int i = 0; i < 5; i++) rd1();
    check_eq("ovf_wrap_x1", 32'(x1Data), 10);

    // Continuous readEn over two samples, write+loadDone in the same cycle.
    cycle(0, 0, '0, '0, '0, 0, 1, 0);
    wr(7'd33, 7'd44, T_NEG);
    cycle(0, 1, 7'd55, 7'd66, T_POS, 1, 0, 0);
    check_eq("wl_count", 32'(count), 2);
    eend_seen = 0;
    for (int i = 0; i < 6; i++) begin
      rd1();
      if (epochEnd) eend_seen++;
    end
`ifdef FEEDER_EPOCH_LIMIT_EN
    check_eq("cont_eends", 32'(eend_seen), 2);
`else
    check_eq("cont_eends", 32'(eend_seen), 3);
`endif

    // Clear while readEn active: outputs hold, everything else drops.
    cycle(0, 0, '0, '0, '0, 0, 1, 0);
    wr(7'd1, 7'd2, T_POS);
    cycle(0, 0, '0, '0, '0, 1, 0, 0);
    rd1();
    held_x1 = x1Data;
    cycle(0, 0, '0, '0, '0, 0, 1, 1);
    check_eq("clr_serving", 32'(serving), 0);
    check_eq("clr_valid", 32'(sampleValid), 0);
    check_eq("clr_count", 32'(count), 0);
    rd1();
    check_eq("clr_hold_x1", 32'(x1Data), 32'(held_x1));

    // Three samples, eight pulses (epoch limit if built in).
    wr(7'd3, 7'd4, T_POS);
    wr(7'd5, 7'd6, T_NEG);
    wr(7'd7, 7'd8, T_POS);
    cycle(0, 0, '0, '0, '0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      rd1();
      idle();
    end
`ifdef FEEDER_EPOCH_LIMIT_EN
    check_eq("lim_frozen_x1", 32'(x1Data), 7);
    check_eq("lim_serving", 32'(serving), 0);
`else
    check_eq("nolim_x1", 32'(x1Data), 5);
    check_eq("nolim_serving", 32'(serving), 1);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1,
            7'($urandom), 7'($urandom), 2'($urandom),
            $urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0,
            $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
